// File: rtl/sap1_pkg.sv
// Shared definitions for the SAP-1 control sequencer: opcodes, control-word
// bit positions, named control words and the T-state encoding.
package sap1_pkg;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam int CON_CP = 11;
    localparam int CON_EP = 10;
    localparam int CON_LM = 9;
    localparam int CON_CE = 8;
    localparam int CON_LI = 7;
    localparam int CON_EI = 6;
    localparam int CON_LA = 5;
    localparam int CON_EA = 4;
    localparam int CON_SU = 3;
    localparam int CON_EU = 2;
    localparam int CON_LB = 1;
    localparam int CON_LO = 0;

    localparam logic [11:0] CW_NONE     = 12'h000;
    localparam logic [11:0] CW_EP_LM    = (12'd1 << CON_EP) | (12'd1 << CON_LM);
    localparam logic [11:0] CW_CP       = (12'd1 << CON_CP);
    localparam logic [11:0] CW_CE_LI    = (12'd1 << CON_CE) | (12'd1 << CON_LI);
    localparam logic [11:0] CW_EI_LM    = (12'd1 << CON_EI) | (12'd1 << CON_LM);
    localparam logic [11:0] CW_CE_LA    = (12'd1 << CON_CE) | (12'd1 << CON_LA);
    localparam logic [11:0] CW_CE_LB    = (12'd1 << CON_CE) | (12'd1 << CON_LB);
    localparam logic [11:0] CW_EU_LA    = (12'd1 << CON_EU) | (12'd1 << CON_LA);
    localparam logic [11:0] CW_SU_EU_LA = CW_EU_LA | (12'd1 << CON_SU);
    localparam logic [11:0] CW_EA_LO    = (12'd1 << CON_EA) | (12'd1 << CON_LO);

    typedef enum logic [2:0] {
        S_T1   = 3'd0,
        S_T2   = 3'd1,
        S_T3   = 3'd2,
        S_T4   = 3'd3,
        S_T5   = 3'd4,
        S_T6   = 3'd5,
        S_HALT = 3'd6
    } tstate_e;

    function automatic logic [5:0] tstate_onehot(input tstate_e s);
        logic [5:0] oh;
        oh = 6'b000000;
        case (s)
            S_T1:    oh = 6'b000001;
            S_T2:    oh = 6'b000010;
            S_T3:    oh = 6'b000100;
            S_T4:    oh = 6'b001000;
            S_T5:    oh = 6'b010000;
            S_T6:    oh = 6'b100000;
            default: oh = 6'b000000;
        endcase
        return oh;
    endfunction

    function automatic logic is_nop(input logic [3:0] op);
        return !(op == OP_LDA || op == OP_ADD || op == OP_SUB ||
                 op == OP_OUT || op == OP_HLT);
    endfunction

endpackage

// File: rtl/sap1_ring_counter.sv
// T1..T6 ring counter with an absorbing HALT state; holds while run is low
// and wraps to T1 early when the decoder flags the last active T-state.
module sap1_ring_counter
    import sap1_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    run,
    input  logic    last_i,
    input  logic    halt_i,
    output tstate_e state_o
);

    tstate_e state_q, state_d;

    // NOTE: default assignment first so every path of this block assigns state_d and no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (state_q != S_HALT && run) begin
            if (halt_i)
                state_d = S_HALT;
            else if (last_i || state_q == S_T6)
                state_d = S_T1;
            else
                state_d = tstate_e'(state_q + 3'd1);
        end
    end

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset)
            state_q <= S_T1;
        else
            state_q <= state_d;
    end

    assign state_o = state_q;

endmodule

// File: rtl/sap1_controller.sv
// SAP-1 control sequencer: ring counter plus a Moore decode of T-state and
// opcode into the 12-bit control word, gated by reset, run and HALT.
module sap1_controller
    import sap1_pkg::*;
#(
    parameter bit EARLY_END = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [3:0]  opcode,
    output logic [11:0] con,
    output logic        hlt,
    output logic [5:0]  t_state
);

    tstate_e     state;
    logic        is_last;
    logic        halt_req;
    logic [11:0] con_raw;

    sap1_ring_counter u_ring (
        .clk     (clk),
        .reset   (reset),
        .run     (run),
        .last_i  (EARLY_END && is_last),
        .halt_i  (halt_req),
        .state_o (state)
    );

    assign halt_req = (state == S_T4) && (opcode == OP_HLT);

    // Last active T-state per opcode; only consulted when EARLY_END is set.
    always_comb begin
        is_last = 1'b0;
        case (state)
            S_T3:    is_last = is_nop(opcode);
            S_T4:    is_last = (opcode == OP_OUT);
            S_T5:    is_last = (opcode == OP_LDA);
            S_T6:    is_last = 1'b1;
            default: is_last = 1'b0;
        endcase
    end

    always_comb begin
        con_raw = CW_NONE;
        case (state)
            S_T1: con_raw = CW_EP_LM;
            S_T2: con_raw = CW_CP;
            S_T3: con_raw = CW_CE_LI;
            S_T4: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB: con_raw = CW_EI_LM;
                    OP_OUT:                 con_raw = CW_EA_LO;
                    default:                con_raw = CW_NONE;
                endcase
            end
            S_T5: begin
                case (opcode)
                    OP_LDA:         con_raw = CW_CE_LA;
                    OP_ADD, OP_SUB: con_raw = CW_CE_LB;
                    default:        con_raw = CW_NONE;
                endcase
            end
            S_T6: begin
                case (opcode)
                    OP_ADD:  con_raw = CW_EU_LA;
                    OP_SUB:  con_raw = CW_SU_EU_LA;
                    default: con_raw = CW_NONE;
                endcase
            end
            default: con_raw = CW_NONE;
        endcase
    end

    // Pausing must not re-issue CP or loads, and reset hides T1's word.
    assign con     = (reset && run && state != S_HALT) ? con_raw : CW_NONE;
    assign hlt     = reset && (state == S_HALT);
    assign t_state = reset ? tstate_onehot(state) : 6'b000001;

endmodule

// File: tb/tb_sap1_controller.sv
// Scoreboard bench for sap1_controller: one instance per EARLY_END setting,
// stimulus pushes hand-computed expectations, a monitor checks mid-cycle.
module tb_sap1_controller;

    logic        clk = 1'b0;
    logic        rst0, run0, rst1, run1;
    logic [3:0]  op0, op1;
    logic [11:0] con0, con1;
    logic        hlt0, hlt1;
    logic [5:0]  ts0, ts1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          d;
        logic [11:0] c;
        logic        h;
        logic [5:0]  ts;
        string       nm;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    sap1_controller #(.EARLY_END(1'b0)) dut0 (
        .clk(clk), .reset(rst0), .run(run0), .opcode(op0),
        .con(con0), .hlt(hlt0), .t_state(ts0)
    );

    sap1_controller #(.EARLY_END(1'b1)) dut1 (
        .clk(clk), .reset(rst1), .run(run1), .opcode(op1),
        .con(con1), .hlt(hlt1), .t_state(ts1)
    );

    task automatic check(input string nm, input logic [11:0] got, input logic [11:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, got, want, $time);
        end
    endtask

    // Drive one cycle's inputs just after the edge and queue its expectation.
    task automatic cyc(input int d, input logic rst, input logic r, input logic [3:0] op,
                       input logic [11:0] c, input logic h, input logic [5:0] ts,
                       input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        if (d == 0) begin
            rst0 = rst; run0 = r; op0 = op;
        end else begin
            rst1 = rst; run1 = r; op1 = op;
        end
        e.d = d; e.c = c; e.h = h; e.ts = ts; e.nm = nm;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            if (e.d == 0) begin
                check({e.nm, ".con"}, con0, e.c);
                check({e.nm, ".hlt"}, {11'd0, hlt0}, {11'd0, e.h});
                check({e.nm, ".t_state"}, {6'd0, ts0}, {6'd0, e.ts});
            end else begin
                check({e.nm, ".con"}, con1, e.c);
                check({e.nm, ".hlt"}, {11'd0, hlt1}, {11'd0, e.h});
                check({e.nm, ".t_state"}, {6'd0, ts1}, {6'd0, e.ts});
            end
        end
    end

    initial begin
        rst0 = 1'b0; run0 = 1'b1; op0 = 4'h0;
        rst1 = 1'b0; run1 = 1'b1; op1 = 4'h0;

        // Reset held for three cycles, then LDA runs all six T-states.
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 4'h0, 12'h000, 0, 6'b000001, "rst");
        cyc(0, 1, 1, 4'h0, 12'h600, 0, 6'b000001, "lda_t1");
        cyc(0, 1, 1, 4'h0, 12'h800, 0, 6'b000010, "lda_t2");
        cyc(0, 1, 1, 4'h0, 12'h180, 0, 6'b000100, "lda_t3");
        cyc(0, 1, 1, 4'h0, 12'h240, 0, 6'b001000, "lda_t4");
        cyc(0, 1, 1, 4'h0, 12'h120, 0, 6'b010000, "lda_t5");
        cyc(0, 1, 1, 4'h0, 12'h000, 0, 6'b100000, "lda_t6");
        cyc(0, 1, 1, 4'h0, 12'h600, 0, 6'b000001, "wrap_t1");

        // ADD with HLT on the IR during fetch, which must be ignored.
        cyc(0, 1, 1, 4'hF, 12'h800, 0, 6'b000010, "add_t2");
        cyc(0, 1, 1, 4'hF, 12'h180, 0, 6'b000100, "add_t3");
        cyc(0, 1, 1, 4'h1, 12'h240, 0, 6'b001000, "add_t4");
        cyc(0, 1, 1, 4'h1, 12'h102, 0, 6'b010000, "add_t5");
        cyc(0, 1, 1, 4'h1, 12'h024, 0, 6'b100000, "add_t6");
        cyc(0, 1, 1, 4'h2, 12'h600, 0, 6'b000001, "sub_t1");
        cyc(0, 1, 1, 4'h2, 12'h800, 0, 6'b000010, "sub_t2");
        cyc(0, 1, 1, 4'h2, 12'h180, 0, 6'b000100, "sub_t3");
        cyc(0, 1, 1, 4'h2, 12'h240, 0, 6'b001000, "sub_t4");
        cyc(0, 1, 1, 4'h2, 12'h102, 0, 6'b010000, "sub_t5");
        cyc(0, 1, 1, 4'h2, 12'h02C, 0, 6'b100000, "sub_t6");

        // Pause four cycles in T2, resume, then finish an LDA.
        cyc(0, 1, 1, 4'h0, 12'h600, 0, 6'b000001, "p_t1");
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 4'h0, 12'h000, 0, 6'b000010, "paused");
        cyc(0, 1, 1, 4'h0, 12'h800, 0, 6'b000010, "resume_t2");
        cyc(0, 1, 1, 4'h0, 12'h180, 0, 6'b000100, "resume_t3");
        cyc(0, 1, 1, 4'h0, 12'h240, 0, 6'b001000, "p_t4");
        cyc(0, 1, 1, 4'h0, 12'h120, 0, 6'b010000, "p_t5");
        cyc(0, 1, 1, 4'h0, 12'h000, 0, 6'b100000, "p_t6");

        // Reset asserted during ADD T5: T6's 0x024 never appears.
        cyc(0, 1, 1, 4'h1, 12'h600, 0, 6'b000001, "mr_t1");
        cyc(0, 1, 1, 4'h1, 12'h800, 0, 6'b000010, "mr_t2");
        cyc(0, 1, 1, 4'h1, 12'h180, 0, 6'b000100, "mr_t3");
        cyc(0, 1, 1, 4'h1, 12'h240, 0, 6'b001000, "mr_t4");
        cyc(0, 0, 1, 4'h1, 12'h000, 0, 6'b000001, "mr_rst");
        cyc(0, 1, 1, 4'h1, 12'h600, 0, 6'b000001, "mr_back_t1");
        cyc(0, 1, 1, 4'h1, 12'h800, 0, 6'b000010, "mr_back_t2");
        cyc(0, 1, 1, 4'hF, 12'h180, 0, 6'b000100, "mr_back_t3");

        // HLT: T4 silent, then absorbing HALT until reset.
        cyc(0, 1, 1, 4'hF, 12'h000, 0, 6'b001000, "hlt_t4");
        for (int i = 0; i < 10; i++)
            cyc(0, 1, logic'(i % 2), 4'(i), 12'h000, 1, 6'b000000, "halted");
        cyc(0, 0, 1, 4'h0, 12'h000, 0, 6'b000001, "halt_rst");
        cyc(0, 1, 1, 4'h0, 12'h600, 0, 6'b000001, "halt_exit_t1");
        cyc(0, 1, 1, 4'h0, 12'h800, 0, 6'b000010, "halt_exit_t2");

        // EARLY_END instance: OUT, NOP, LDA, ADD.
        cyc(1, 0, 1, 4'hE, 12'h000, 0, 6'b000001, "ee_rst");
        cyc(1, 1, 1, 4'hE, 12'h600, 0, 6'b000001, "ee_out_t1");
        cyc(1, 1, 1, 4'hE, 12'h800, 0, 6'b000010, "ee_out_t2");
        cyc(1, 1, 1, 4'hE, 12'h180, 0, 6'b000100, "ee_out_t3");
        cyc(1, 1, 1, 4'hE, 12'h011, 0, 6'b001000, "ee_out_t4");
        cyc(1, 1, 1, 4'h5, 12'h600, 0, 6'b000001, "ee_nop_t1");
        cyc(1, 1, 1, 4'h5, 12'h800, 0, 6'b000010, "ee_nop_t2");
        cyc(1, 1, 1, 4'h5, 12'h180, 0, 6'b000100, "ee_nop_t3");
        cyc(1, 1, 1, 4'h0, 12'h600, 0, 6'b000001, "ee_lda_t1");
        cyc(1, 1, 1, 4'h0, 12'h800, 0, 6'b000010, "ee_lda_t2");
        cyc(1, 1, 1, 4'h0, 12'h180, 0, 6'b000100, "ee_lda_t3");
        cyc(1, 1, 1, 4'h0, 12'h240, 0, 6'b001000, "ee_lda_t4");
        cyc(1, 1, 1, 4'h0, 12'h120, 0, 6'b010000, "ee_lda_t5");
        cyc(1, 1, 1, 4'h1, 12'h600, 0, 6'b000001, "ee_add_t1");
        cyc(1, 1, 1, 4'h1, 12'h800, 0, 6'b000010, "ee_add_t2");
        cyc(1, 1, 1, 4'h1, 12'h180, 0, 6'b000100, "ee_add_t3");
        cyc(1, 1, 1, 4'h1, 12'h240, 0, 6'b001000, "ee_add_t4");
        cyc(1, 1, 1, 4'h1, 12'h102, 0, 6'b010000, "ee_add_t5");
        cyc(1, 1, 1, 4'h1, 12'h024, 0, 6'b100000, "ee_add_t6");
        cyc(1, 1, 1, 4'h1, 12'h600, 0, 6'b000001, "ee_add_wrap");

        @(negedge clk);
        #1;
        check("scoreboard_drained", 12'(sb.size()), 12'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
